neuron_update_ctrl: RTL and testbench

Per-timestep neuron integration sequencer that drives the status memory read/write ports.
- On each tick it walks every neuron: reads Bias, MembPot and Th over the neuron-state read port, and accumulates synaptic weights over the weight read port for every axon that spiked.
- It compares the result with the threshold, writes the new MembPot back over the neuron-state write port, and emits a spike event.
- It sits between the tick/axon-spike input logic and the status memory, and is the sole master of ports A, B and E during a tick.

---
 rtl/neuron_update_ctrl_pkg.sv | 41 ++++
 rtl/neuron_update_ctrl_acc.sv | 38 +++
 rtl/neuron_update_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_neuron_update_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_update_ctrl_pkg.sv
// Shared types and arithmetic for the neuron update sequencer.
package neuron_update_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        POT,
        TH,
        AXON,
        DRAIN,
        WR
    } nurnState_t;

    localparam logic [1:0] SEL_BIAS = 2'b00;
    localparam logic [1:0] SEL_POT  = 2'b01;
    localparam logic [1:0] SEL_TH   = 2'b10;

    localparam int         DSIZE_DEF = 16;
    localparam logic [DSIZE_DEF-1:0] DATA_MAX = {1'b0, {(DSIZE_DEF-1){1'b1}}};
    localparam logic [DSIZE_DEF-1:0] DATA_MIN = {1'b1, {(DSIZE_DEF-1){1'b0}}};

    // Operands arrive sign-extended to 32 bits; width must be <= 31 so the raw sum cannot overflow.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          width);
        logic signed [31:0] sum;
        logic signed [31:0] maxV;
        logic signed [31:0] minV;
        sum  = $signed(a) + $signed(b);
        maxV = (32'sd1 <<< (width - 1)) - 32'sd1;
        minV = -(32'sd1 <<< (width - 1));
        if (sum > maxV) begin
            sat_add = maxV;
        end else if (sum < minV) begin
            sat_add = minV;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/neuron_update_ctrl_acc.sv
// Registered saturating accumulator: load has priority over add.
module nurn_sat_acc
    import neuron_update_ctrl_pkg::*;
#(
    parameter int DSIZE = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [DSIZE-1:0] loadVal_i,
    input  logic             addEn_i,
    input  logic [DSIZE-1:0] addVal_i,
    output logic [DSIZE-1:0] acc_o
);

    logic [DSIZE-1:0]  accQ;
    logic [31:0]       sumFull;
    logic [31-DSIZE:0] unusedSatHi;

    assign sumFull = sat_add({{(32-DSIZE){accQ[DSIZE-1]}}, accQ},
                             {{(32-DSIZE){addVal_i[DSIZE-1]}}, addVal_i},
                             DSIZE);
    // Upper bits are only sign copies of the clamped result.
    assign unusedSatHi = sumFull[31:DSIZE];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            accQ <= '0;
        end else if (load_i) begin
            accQ <= loadVal_i;
        end else if (addEn_i) begin
            accQ <= sumFull[DSIZE-1:0];
        end
    end

    assign acc_o = accQ;

endmodule

// File: rtl/neuron_update_ctrl.sv
// Per-tick neuron integration sequencer; sole master of status ports A, B and E while busy.
//   state | meaning
//   IDLE  | waiting for start_i
//   BIAS  | read Bias over port A
//   POT   | load acc with Bias, read MembPot
//   TH    | add MembPot, read Th
//   AXON  | capture Th, read weights of spiking axons, accumulate
//   DRAIN | accumulate the last pending weight
//   WR    | threshold compare, write MembPot, emit spike
module neuron_update_ctrl
    import neuron_update_ctrl_pkg::*;
#(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_n_i,
    input  logic                                       start_i,
    input  logic [NUM_AXONS-1:0]                       axonSpike_i,
    output logic [NURN_CNT_BIT_WIDTH+1:0]              Addr_StatRd_A_o,
    output logic                                       rdEn_StatRd_A_o,
    input  logic [DSIZE-1:0]                           data_StatRd_A_i,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o,
    output logic                                       rdEn_StatRd_E_o,
    input  logic [DSIZE-1:0]                           data_StatRd_E_i,
    output logic [NURN_CNT_BIT_WIDTH+1:0]              Addr_StatWr_B_o,
    output logic                                       wrEn_StatWr_B_o,
    output logic [DSIZE-1:0]                           data_StatWr_B_o,
    output logic                                       spike_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]              spikeNurnId_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam logic [NURN_CNT_BIT_WIDTH-1:0] LAST_NURN = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
    localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_AXON = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

    nurnState_t                    stateQ, stateD;
    logic [NURN_CNT_BIT_WIDTH-1:0] nQ;
    logic [AXON_CNT_BIT_WIDTH-1:0] jQ;
    logic [NUM_AXONS-1:0]          spkVec;
    logic [DSIZE-1:0]              thReg;
    logic                          rdEnEQ;
    logic                          busyQ;

    logic                          accLoad;
    logic                          accAdd;
    logic [DSIZE-1:0]              accAddVal;
    logic [DSIZE-1:0]              accVal;
    logic                          lastNurn;

    assign lastNurn = (nQ == LAST_NURN);

    // Bias loads in POT, MembPot adds in TH, weights add one cycle after their read.
    assign accLoad   = (stateQ == POT);
    assign accAdd    = (stateQ == TH) || rdEnEQ;
    assign accAddVal = (stateQ == TH) ? data_StatRd_A_i : data_StatRd_E_i;

    nurn_sat_acc #(
        .DSIZE(DSIZE)
    ) uAcc (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load_i    (accLoad),
        .loadVal_i (data_StatRd_A_i),
        .addEn_i   (accAdd),
        .addVal_i  (accAddVal),
        .acc_o     (accVal)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            nQ     <= '0;
            jQ     <= '0;
            spkVec <= '0;
            thReg  <= '0;
            rdEnEQ <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            rdEnEQ <= rdEn_StatRd_E_o;
            case (stateQ)
                IDLE: begin
                    if (start_i) begin
                        spkVec <= axonSpike_i;
                        nQ     <= '0;
                        busyQ  <= 1'b1;
                    end
                end
                TH: begin
                    jQ <= '0;
                end
                AXON: begin
                    jQ <= jQ + AXON_CNT_BIT_WIDTH'(1);
                    if (jQ == '0) begin
                        thReg <= data_StatRd_A_i;
                    end
                end
                WR: begin
                    if (lastNurn) begin
                        busyQ <= 1'b0;
                    end else begin
                        nQ <= nQ + NURN_CNT_BIT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateD          = stateQ;
        Addr_StatRd_A_o = '0;
        rdEn_StatRd_A_o = 1'b0;
        Addr_StatRd_E_o = '0;
        rdEn_StatRd_E_o = 1'b0;
        Addr_StatWr_B_o = '0;
        wrEn_StatWr_B_o = 1'b0;
        data_StatWr_B_o = '0;
        spike_o         = 1'b0;
        spikeNurnId_o   = '0;
        done_o          = 1'b0;
        case (stateQ)
            IDLE: begin
                if (start_i) begin
                    stateD = BIAS;
                end
            end
            BIAS: begin
                rdEn_StatRd_A_o = 1'b1;
                Addr_StatRd_A_o = {nQ, SEL_BIAS};
                stateD          = POT;
            end
            POT: begin
                rdEn_StatRd_A_o = 1'b1;
                Addr_StatRd_A_o = {nQ, SEL_POT};
                stateD          = TH;
            end
            TH: begin
                rdEn_StatRd_A_o = 1'b1;
                Addr_StatRd_A_o = {nQ, SEL_TH};
                stateD          = AXON;
            end
            AXON: begin
                rdEn_StatRd_E_o = spkVec[jQ];
                Addr_StatRd_E_o = {nQ, jQ};
                if (jQ == LAST_AXON) begin
                    stateD = DRAIN;
                end
            end
            DRAIN: begin
                stateD = WR;
            end
            WR: begin
                wrEn_StatWr_B_o = 1'b1;
                Addr_StatWr_B_o = {nQ, SEL_POT};
                if ($signed(accVal) >= $signed(thReg)) begin
                    spike_o         = 1'b1;
                    spikeNurnId_o   = nQ;
                    data_StatWr_B_o = '0;
                end else begin
                    data_StatWr_B_o = accVal;
                end
                if (lastNurn) begin
                    done_o = 1'b1;
                    stateD = IDLE;
                end else begin
                    stateD = BIAS;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    assign busy_o = busyQ;

endmodule

// File: tb/tb_neuron_update_ctrl.sv
// Scoreboard bench: 4 neurons x 4 axons against a registered status-memory model.
module tb_neuron_update_ctrl;
    import neuron_update_ctrl_pkg::*;

    localparam int NN = 4;
    localparam int NA = 4;
    localparam int DW = 16;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic [NA-1:0] axonSpike_i = '0;
    logic [3:0]    addrA, addrE, addrB;
    logic          rdEnA, rdEnE, wrEnB;
    logic [DW-1:0] dataA = '0, dataE = '0, dataB;
    logic          spike_o, busy_o, done_o;
    logic [1:0]    spikeId;

    neuron_update_ctrl #(
        .NUM_NURNS(NN), .NUM_AXONS(NA), .DSIZE(DW),
        .NURN_CNT_BIT_WIDTH(2), .AXON_CNT_BIT_WIDTH(2)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .axonSpike_i(axonSpike_i),
        .Addr_StatRd_A_o(addrA), .rdEn_StatRd_A_o(rdEnA), .data_StatRd_A_i(dataA),
        .Addr_StatRd_E_o(addrE), .rdEn_StatRd_E_o(rdEnE), .data_StatRd_E_i(dataE),
        .Addr_StatWr_B_o(addrB), .wrEn_StatWr_B_o(wrEnB), .data_StatWr_B_o(dataB),
        .spike_o(spike_o), .spikeNurnId_o(spikeId), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Status memory model with a bench-side load port.
    logic [DW-1:0] memA [16];
    logic [DW-1:0] memE [16];
    logic          ldEn = 1'b0, ldIsE = 1'b0;
    logic [3:0]    ldAddr = '0;
    logic [DW-1:0] ldData = '0;

    always @(posedge clk_i) begin
        if (ldEn) begin
            if (ldIsE) memE[ldAddr] <= ldData;
            else       memA[ldAddr] <= ldData;
        end
        if (wrEnB) memA[addrB] <= dataB;
        if (rdEnA) dataA <= memA[addrA];
        if (rdEnE) dataE <= memE[addrE];
    end

    typedef struct packed {
        logic [1:0]    nid;
        logic [DW-1:0] data;
        logic          spk;
    } exp_t;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   eReads[NN] = '{0, 0, 0, 0};

    logic [DW-1:0] biasV [NN] = '{16'd2, 16'd0, 16'd0, 16'hFFFB};
    logic [DW-1:0] potV  [NN] = '{16'd3, 16'h7FF0, 16'h8010, 16'd1};
    logic [DW-1:0] thV   [NN] = '{16'd20, 16'h7FFF, 16'd0, 16'hFFFF};
    logic [DW-1:0] wgtV  [16] = '{16'd5, 16'd6, 16'd7, 16'd8,
                                  16'h0100, 16'd0, 16'd0, 16'd0,
                                  16'hFF00, 16'd0, 16'd0, 16'd0,
                                  16'd1, 16'd1, 16'd1, 16'd1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            exp_t e;
            if (rdEnE) eReads[addrE[3:2]]++;
            if (wrEnB) begin
                if (sbQ.size() == 0) begin
                    chk("unexpected_write", {addrB, dataB}, 0);
                end else begin
                    e = sbQ.pop_front();
                    chk("wr_addr", addrB, {e.nid, 2'b01});
                    chk("wr_data", dataB, e.data);
                    chk("wr_spike", spike_o, e.spk);
                    if (e.spk) chk("spike_id", spikeId, e.nid);
                end
            end else if (spike_o) begin
                chk("spike_without_write", spike_o, 0);
            end
        end
    end

    task automatic loadWord(input logic isE, input logic [3:0] a, input logic [DW-1:0] d);
        ldIsE = isE; ldAddr = a; ldData = d; ldEn = 1'b1;
        @(posedge clk_i); #1;
        ldEn = 1'b0;
    endtask

    task automatic loadImage();
        for (int n = 0; n < NN; n++) begin
            loadWord(1'b0, 4'(n*4 + 0), biasV[n]);
            loadWord(1'b0, 4'(n*4 + 1), potV[n]);
            loadWord(1'b0, 4'(n*4 + 2), thV[n]);
            for (int j = 0; j < NA; j++) loadWord(1'b1, 4'(n*4 + j), wgtV[n*4 + j]);
        end
    endtask

    task automatic pushExp(input logic [1:0] n, input logic [DW-1:0] d, input logic s);
        exp_t e;
        e.nid = n; e.data = d; e.spk = s;
        sbQ.push_back(e);
    endtask

    task automatic pushTickSpiking();
        pushExp(2'd0, 16'd0, 1'b1);      // 2+3+5+6+8=24 >= 20
        pushExp(2'd1, 16'd0, 1'b1);      // clamps at DATA_MAX == th
        pushExp(2'd2, DATA_MIN, 1'b0);   // clamps at DATA_MIN
        pushExp(2'd3, 16'd0, 1'b1);      // -5+1+3 = -1 == th
    endtask

    // Issues start, then counts cycles from the first BIAS cycle up to done_o.
    task automatic runTick(input logic [NA-1:0] spk, input logic midStart, input string tag);
        int cnt;
        int busyLow;
        axonSpike_i = spk;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        axonSpike_i = 4'b1111;
        cnt = 1;
        busyLow = 0;
        while (!done_o && cnt < 100) begin
            if (!busy_o) busyLow++;
            start_i = midStart && (cnt == 10);
            @(posedge clk_i); #1;
            cnt++;
        end
        start_i = 1'b0;
        chk({tag, "_done_seen"}, done_o, 1);
        chk({tag, "_tick_len"}, cnt, NN * (NA + 5));
        chk({tag, "_busy_low"}, busyLow, 0);
        chk({tag, "_busy_at_done"}, busy_o, 1);
        @(posedge clk_i); #1;
        chk({tag, "_busy_after"}, busy_o, 0);
        chk({tag, "_done_pulse"}, done_o, 0);
        chk({tag, "_sb_empty"}, sbQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap[NN];
        int eTot;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_ctrl", {busy_o, done_o, spike_o, spikeId, wrEnB, addrB, dataB}, 0);
        chk("reset_rd", {rdEnA, addrA, rdEnE, addrE}, 0);
        rst_n_i = 1'b1;

        loadImage();
        pushTickSpiking();
        snap = eReads;
        runTick(4'b1011, 1'b0, "t1");
        chk("t1_n0_ereads", eReads[0] - snap[0], 3);
        eTot = 0;
        for (int n = 0; n < NN; n++) eTot += eReads[n] - snap[n];
        chk("t1_total_ereads", eTot, 12);

        loadImage();
        pushExp(2'd0, 16'd5, 1'b0);
        pushExp(2'd1, 16'h7FF0, 1'b0);
        pushExp(2'd2, 16'h8010, 1'b0);
        pushExp(2'd3, 16'hFFFC, 1'b0);
        snap = eReads;
        runTick(4'b0000, 1'b1, "t2");
        eTot = 0;
        for (int n = 0; n < NN; n++) eTot += eReads[n] - snap[n];
        chk("t2_no_ereads", eTot, 0);

        loadImage();
        pushExp(2'd0, 16'd0, 1'b1);
        pushExp(2'd1, 16'd0, 1'b1);
        axonSpike_i = 4'b1011;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (22) @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("midrst_ctrl", {busy_o, done_o, spike_o, spikeId, wrEnB, addrB, dataB}, 0);
        chk("midrst_rd", {rdEnA, addrA, rdEnE, addrE}, 0);
        chk("midrst_sb_empty", sbQ.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("midrst_n2_untouched", memA[9], 16'h8010);
        chk("midrst_n0_kept", memA[1], 16'd0);
        chk("midrst_n1_kept", memA[5], 16'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        loadImage();
        pushTickSpiking();
        runTick(4'b1011, 1'b0, "t3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
